// File: rtl/parallel_to_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : parallel_to_serial_pkg
//  Brief    : Shared counter-width helpers for the parallel-to-serial slice.
//  Revision : 1.0 - initial release
// ============================================================================
package parallel_to_serial_pkg;

    // Width of the per-word bit counter (counts 0 .. width-1).
    function automatic int bit_cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // Width of the FIFO occupancy counter (counts 0 .. depth).
    function automatic int fifo_cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Width of a FIFO pointer (indexes 0 .. depth-1); at least one bit.
    function automatic int fifo_ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/p2s_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : p2s_word_fifo
//  Brief    : Register-based word FIFO with same-cycle push and pop.
//  Revision : 1.0 - initial release
// ============================================================================
module p2s_word_fifo
    import parallel_to_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int c_cnt_w = fifo_cnt_width(DEPTH);
    localparam int c_ptr_w = fifo_ptr_width(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign empty   = (r_count == '0);
    assign full    = (r_count == c_cnt_w'(DEPTH));
    assign rd_data = r_mem[r_rd_ptr];

    // Storage array; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap at DEPTH-1; count is unchanged on simultaneous push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/parallel_to_serial.sv
`default_nettype none
// ============================================================================
//  Module   : parallel_to_serial
//  Brief    : Word-to-bitstream converter, LSB first, valid/ready on both
//             sides, with a small word FIFO ahead of the shift register.
//  Revision : 1.0 - initial release
// ============================================================================
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             parallel_valid,
    output logic             parallel_ready,
    input  logic [WIDTH-1:0] parallel_data,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             serial_data,
    output logic             busy
);

    localparam int c_cnt_w = bit_cnt_width(WIDTH);

    generate
        if (WIDTH < 2 || DEPTH < 1) begin : g_bad_params
            $fatal(1, "parallel_to_serial: WIDTH must be >= 2 and DEPTH >= 1");
        end
    endgenerate

    logic [WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic               r_shreg_full;

    logic               w_accept;
    logic               w_consume;
    logic               w_last_bit;
    logic               w_load_slot;
    logic               w_fifo_pop;
    logic               w_fifo_push;
    logic               w_bypass;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [WIDTH-1:0]   w_fifo_rd_data;

    // Ready depends only on registered FIFO state, never on serial_ready.
    assign parallel_ready = rst_n && !w_fifo_full;
    assign serial_valid   = r_shreg_full;
    assign serial_data    = r_shreg[0];
    assign busy           = r_shreg_full || !w_fifo_empty;

    assign w_accept    = parallel_valid && parallel_ready;
    assign w_consume   = r_shreg_full && serial_ready;
    assign w_last_bit  = w_consume && (r_bit_cnt == c_cnt_w'(WIDTH - 1));

    // The shifter can take a new word when empty or as its last bit leaves.
    assign w_load_slot = !r_shreg_full || w_last_bit;
    assign w_fifo_pop  = w_load_slot && !w_fifo_empty;
    // An empty FIFO lets the incoming word go straight into the shifter.
    assign w_bypass    = w_load_slot && w_fifo_empty && w_accept;
    assign w_fifo_push = w_accept && !w_bypass;

    p2s_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_fifo_push),
        .pop     (w_fifo_pop),
        .wr_data (parallel_data),
        .rd_data (w_fifo_rd_data),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full)
    );

    // Shifter: reload from FIFO head or bypass word, otherwise shift on each consumed bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_shreg_full <= 1'b0;
        end else if (w_fifo_pop) begin
            r_shreg      <= w_fifo_rd_data;
            r_bit_cnt    <= '0;
            r_shreg_full <= 1'b1;
        end else if (w_bypass) begin
            r_shreg      <= parallel_data;
            r_bit_cnt    <= '0;
            r_shreg_full <= 1'b1;
        end else if (w_consume) begin
            r_shreg   <= {1'b0, r_shreg[WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
            if (w_last_bit) begin
                r_shreg_full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parallel_to_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parallel_to_serial
//  Brief    : Directed self-checking bench for parallel_to_serial.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_parallel_to_serial;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic             parallel_valid;
    logic             parallel_ready;
    logic [WIDTH-1:0] parallel_data;
    logic             serial_valid;
    logic             serial_ready;
    logic             serial_data;
    logic             busy;

    int n_checks = 0;
    int n_fails  = 0;

    parallel_to_serial #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .parallel_valid (parallel_valid),
        .parallel_ready (parallel_ready),
        .parallel_data  (parallel_data),
        .serial_valid   (serial_valid),
        .serial_ready   (serial_ready),
        .serial_data    (serial_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Hand-computed LSB-first bit streams.
    int t1_bits [8]  = '{1,0,1,0,0,1,0,1};                         // 8'hA5
    int t2_bits [16] = '{1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1};        // 8'h01, 8'h80
    int t3_bits [8]  = '{1,1,0,0,0,0,1,1};                         // 8'hC3
    int t5_bits [8]  = '{0,1,0,1,1,0,1,0};                         // 8'h5A
    logic [7:0] t4_words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int          k;
        int          held;
        bit          prev_stall;
        bit          rdy;
        logic [7:0]  rx;
        int          nbits;
        int          widx;
        logic [7:0]  sent_q [$];
        logic [7:0]  exp_w;
        int          sent;
        int          rx_words;
        int          handshakes;

        rst_n = 1'b0; parallel_valid = 1'b0; parallel_data = '0; serial_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(serial_valid), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_data",  32'(serial_data), 0);
        check("rst_ready", 32'(parallel_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(parallel_ready), 1);

        // ---------------- test 1: single word A5 ----------------
        parallel_valid = 1'b1; parallel_data = 8'hA5; serial_ready = 1'b1;
        @(negedge clk);
        parallel_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t1_valid", 32'(serial_valid), 1);
            check("t1_bit",   32'(serial_data), 32'(t1_bits[i]));
            @(negedge clk);
        end
        check("t1_valid_end", 32'(serial_valid), 0);
        check("t1_busy_end",  32'(busy), 0);

        // ---------------- test 2: back-to-back 01, 80 ----------------
        parallel_valid = 1'b1; parallel_data = 8'h01;
        @(negedge clk);
        parallel_data = 8'h80;
        for (int i = 0; i < 16; i++) begin
            check("t2_valid", 32'(serial_valid), 1);
            check("t2_bit",   32'(serial_data), 32'(t2_bits[i]));
            if (i == 0) check("t2_ready", 32'(parallel_ready), 1);
            if (i == 1) parallel_valid = 1'b0;
            @(negedge clk);
        end
        check("t2_valid_end", 32'(serial_valid), 0);

        // ---------------- test 3: C3 with toggling serial_ready ----------------
        parallel_valid = 1'b1; parallel_data = 8'hC3; serial_ready = 1'b0;
        @(negedge clk);
        parallel_valid = 1'b0;
        k = 0; prev_stall = 1'b0; held = 0;
        for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
            check("t3_valid", 32'(serial_valid), 1);
            if (prev_stall) check("t3_stable", 32'(serial_data), 32'(held));
            serial_ready = (cyc % 2 == 0);
            if (serial_ready) begin
                check("t3_bit", 32'(serial_data), 32'(t3_bits[k]));
                k++;
                prev_stall = 1'b0;
            end else begin
                held = int'(serial_data);
                prev_stall = 1'b1;
            end
            @(negedge clk);
        end
        check("t3_handshakes", 32'(k), 8);
        check("t3_valid_end",  32'(serial_valid), 0);

        // ---------------- test 4: capacity DEPTH+1 ----------------
        serial_ready = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            parallel_valid = 1'b1;
            parallel_data  = t4_words[k];
            rdy = parallel_ready;
            @(negedge clk);
            if (rdy) k++;
        end
        check("t4_accepted", 32'(k), 3);
        check("t4_ready_full", 32'(parallel_ready), 0);
        check("t4_busy", 32'(busy), 1);
        serial_ready = 1'b1;
        parallel_data = t4_words[3];
        nbits = 0; widx = 0; rx = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < 8)  check("t4_ready_low", 32'(parallel_ready), 0);
            if (i == 8) check("t4_ready_back", 32'(parallel_ready), 1);
            if (i == 9) parallel_valid = 1'b0;
            check("t4_valid", 32'(serial_valid), 1);
            rx = {serial_data, rx[7:1]};
            nbits++;
            if (nbits == 8) begin
                check("t4_word", 32'(rx), 32'(t4_words[widx]));
                widx++;
                nbits = 0;
            end
            @(negedge clk);
        end
        check("t4_valid_end", 32'(serial_valid), 0);
        check("t4_busy_end",  32'(busy), 0);

        // ---------------- test 5: reset mid-word ----------------
        parallel_valid = 1'b1; parallel_data = 8'hFF; serial_ready = 1'b1;
        @(negedge clk);
        parallel_data = 8'h33;           // queued behind FF
        @(negedge clk);
        parallel_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);                  // three bits of FF consumed
        check("t5_valid_pre", 32'(serial_valid), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_valid", 32'(serial_valid), 0);
        check("t5_rst_busy",  32'(busy), 0);
        check("t5_rst_ready", 32'(parallel_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_rel_ready", 32'(parallel_ready), 1);
        check("t5_rel_valid", 32'(serial_valid), 0);
        parallel_valid = 1'b1; parallel_data = 8'h5A;
        @(negedge clk);
        parallel_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t5_valid", 32'(serial_valid), 1);
            check("t5_bit",   32'(serial_data), 32'(t5_bits[i]));
            @(negedge clk);
        end
        check("t5_valid_end", 32'(serial_valid), 0);
        check("t5_busy_end",  32'(busy), 0);

        // ---------------- test 6: random loopback ----------------
        sent = 0; rx_words = 0; handshakes = 0; nbits = 0; rx = '0;
        for (int cyc = 0; cyc < 20000 && rx_words < 100; cyc++) begin
            parallel_valid = (sent < 100) && ($urandom_range(0, 1) == 1);
            parallel_data  = 8'($urandom);
            serial_ready   = ($urandom_range(0, 1) == 1);
            if (parallel_valid && parallel_ready) begin
                sent_q.push_back(parallel_data);
                sent++;
            end
            if (serial_valid && serial_ready) begin
                handshakes++;
                rx = {serial_data, rx[7:1]};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    exp_w = (sent_q.size() > 0) ? sent_q.pop_front() : 8'hxx;
                    check("t6_word", 32'(rx), 32'(exp_w));
                    rx_words++;
                end
            end
            @(negedge clk);
        end
        parallel_valid = 1'b0;
        serial_ready   = 1'b0;
        check("t6_words",      32'(rx_words), 100);
        check("t6_handshakes", 32'(handshakes), 800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
